usb_trsac_sched: RTL
====================

USB_TRSAC_SCHED -- requirements
Module: usb_trsac_sched

Interface
REQ-001 Parameter BIT_CLKS, default 4, clock cycles per USB bit time.
REQ-002 Parameter TX_DELAY_BITS, default 2, interpacket delay in bit times before a device transmit.
REQ-003 Parameter RX_TIMEOUT_BITS, default 18, bit times to wait for a host packet before giving up.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rx_done  in  1  one-cycle pulse: valid packet decoded; rx_pid is valid in the same cycle.
REQ-007 rx_pid  in  4  low nibble of received PID (OUT 0001, IN 1001, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010).
REQ-008 rx_err  in  1  one-cycle pulse: CRC, stuffing, PID or EOP error.
REQ-009 tx_done  in  1  one-cycle pulse: transmitter finished EOP.
REQ-010 app_ready  in  1  IN data available; app_stall  in  1  endpoint halted; app_out_ack  in  1  OUT buffer can accept data.
REQ-011 tx_start  out  1  one-cycle pulse to start transmit; tx_pid  out  4  PID to send, held stable from tx_start to tx_done.
REQ-012 out_commit  out  1  pulse: OUT/SETUP data accepted; in_commit  out  1  pulse: IN data acknowledged by host.
REQ-013 trsac_timeout  out  1  pulse on any wait timeout; busy  out  1  high whenever state is not IDLE; data_toggle  out  1  current toggle.

Function
REQ-014 States: IDLE, WAIT_DATA, TX_DLY, TX, WAIT_HS; one-hot or binary encoding is left to the implementation.
REQ-015 IDLE, rx_done with IN: latch tx_pid = STALL (1110) if app_stall, else DATA0/DATA1 per data_toggle if app_ready, else NAK (1010); go to TX_DLY.
REQ-016 IDLE, rx_done with OUT or SETUP: latch token kind; go to WAIT_DATA. Any other PID, or rx_err, leaves the block in IDLE with no output.
REQ-017 WAIT_DATA, rx_done with DATA0/DATA1 after SETUP: tx_pid = ACK; out_commit pulses; data_toggle is set to 1; go to TX_DLY.
REQ-018 WAIT_DATA, rx_done with DATA0/DATA1 after OUT: if app_stall, tx_pid = STALL; else if !app_out_ack, tx_pid = NAK; else ACK.
REQ-019 For an ACK in REQ-018, out_commit pulses and data_toggle flips only when the received DATA PID matches data_toggle; on a mismatch, ACK is sent with no commit and no flip.
REQ-020 WAIT_DATA, rx_done with a non-DATA PID, or rx_err: go to IDLE with no response.
REQ-021 WAIT_DATA and WAIT_HS timeout: counter reaches RX_TIMEOUT_BITS*BIT_CLKS cycles after state entry -> trsac_timeout pulse, go to IDLE.
REQ-022 TX_DLY: wait exactly TX_DELAY_BITS*BIT_CLKS cycles after entry, then pulse tx_start for one cycle and enter TX.
REQ-023 TX: wait for tx_done; if tx_pid is DATA0/DATA1, go to WAIT_HS, else go to IDLE. TX has no timeout.
REQ-024 WAIT_HS, rx_done with ACK: in_commit pulses, data_toggle flips, go to IDLE. Any other PID or rx_err: go to IDLE, toggle unchanged.
REQ-025 app_* inputs are sampled only in the cycle of the deciding rx_done.
REQ-026 Priority within one cycle: rx_err > rx_done > timeout; rx_done is ignored in TX_DLY and TX.
REQ-027 Timers are at least clog2(max count)+1 bits wide, restart at every state entry, and never wrap.
REQ-028 Decision latency: the state and tx_pid update on the clock edge that samples rx_done; output pulses are registered and last exactly one cycle.

Reset
REQ-029 With rst high at a clock edge: state IDLE, tx_pid 0000, data_toggle 0, and all pulse outputs and busy are 0.
REQ-030 Reset mid-operation aborts any wait or pending tx_start with no commit or timeout pulse.

Verification
REQ-031 IN token, app_ready=1, toggle 0 -> tx_start 8 cycles later with tx_pid 0011; then host ACK -> in_commit, toggle 1.
REQ-032 OUT token, then DATA0 with app_out_ack=1 -> tx_pid 0010, out_commit, toggle 1; a repeated DATA0 -> ACK, no commit.
REQ-033 SETUP token then DATA0 while toggle 1 -> ACK, out_commit, toggle 1; OUT with app_stall -> tx_pid 1110.
REQ-034 IN token with app_ready=0 -> NAK, return to IDLE after tx_done; no WAIT_HS entered.
REQ-035 OUT token with no data for 72 cycles -> trsac_timeout at cycle 72, IDLE; rx_err during WAIT_HS -> IDLE, toggle unchanged.
REQ-036 rst asserted in TX_DLY -> no tx_start, IDLE, toggle 0 on the next cycle.

Source files
------------

// File: rtl/usb_trsac_sched.sv
`default_nettype none
// ============================================================================
// Module   : usb_trsac_sched
// Purpose  : USB device-side transaction scheduler. Decodes host tokens,
//            chooses the handshake or data PID to return, times the
//            interpacket delay and the receive timeouts, and keeps the
//            endpoint's DATA0/DATA1 toggle.
// Revision : 1.0 - initial release
// ============================================================================
module usb_trsac_sched #(
  parameter int BIT_CLKS        = 4,
  parameter int TX_DELAY_BITS   = 2,
  parameter int RX_TIMEOUT_BITS = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [3:0] rx_pid,
  input  logic       rx_err,
  input  logic       tx_done,
  input  logic       app_ready,
  input  logic       app_stall,
  input  logic       app_out_ack,
  output logic       tx_start,
  output logic [3:0] tx_pid,
  output logic       out_commit,
  output logic       in_commit,
  output logic       trsac_timeout,
  output logic       busy,
  output logic       data_toggle
);

  localparam int C_RX_LIMIT  = RX_TIMEOUT_BITS * BIT_CLKS;
  localparam int C_DLY_LIMIT = TX_DELAY_BITS * BIT_CLKS;
  localparam int C_T_MAX     = (C_RX_LIMIT > C_DLY_LIMIT) ? C_RX_LIMIT : C_DLY_LIMIT;
  localparam int C_TW        = $clog2(C_T_MAX) + 1;

  // Timer value seen in the last cycle of a wait; the edge that samples it
  // is exactly LIMIT cycles after state entry.
  localparam logic [C_TW-1:0] C_RX_LAST  = C_TW'(C_RX_LIMIT - 1);
  localparam logic [C_TW-1:0] C_DLY_LAST = C_TW'(C_DLY_LIMIT - 1);

  localparam logic [3:0] C_PID_OUT   = 4'b0001;
  localparam logic [3:0] C_PID_IN    = 4'b1001;
  localparam logic [3:0] C_PID_SETUP = 4'b1101;
  localparam logic [3:0] C_PID_DATA0 = 4'b0011;
  localparam logic [3:0] C_PID_DATA1 = 4'b1011;
  localparam logic [3:0] C_PID_ACK   = 4'b0010;
  localparam logic [3:0] C_PID_NAK   = 4'b1010;
  localparam logic [3:0] C_PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_TX_DLY    = 3'd2,
    S_TX        = 3'd3,
    S_WAIT_HS   = 3'd4
  } state_t;

  state_t            r_state, w_state_n;
  logic [C_TW-1:0]   r_timer;
  logic              r_setup, w_setup_n;
  logic [3:0]        r_tx_pid, w_tx_pid_n;
  logic              r_toggle, w_toggle_n;
  logic              r_tx_start, w_tx_start_n;
  logic              r_out_commit, w_out_commit_n;
  logic              r_in_commit, w_in_commit_n;
  logic              r_timeout, w_timeout_n;

  logic w_rx_is_data;
  logic w_tx_is_data;
  logic w_rx_last;

  assign w_rx_is_data = (rx_pid == C_PID_DATA0) || (rx_pid == C_PID_DATA1);
  assign w_tx_is_data = (r_tx_pid == C_PID_DATA0) || (r_tx_pid == C_PID_DATA1);
  assign w_rx_last    = (r_timer == C_RX_LAST);

  // State register, decision registers and one-cycle output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_setup      <= 1'b0;
      r_tx_pid     <= 4'b0000;
      r_toggle     <= 1'b0;
      r_tx_start   <= 1'b0;
      r_out_commit <= 1'b0;
      r_in_commit  <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_setup      <= w_setup_n;
      r_tx_pid     <= w_tx_pid_n;
      r_toggle     <= w_toggle_n;
      r_tx_start   <= w_tx_start_n;
      r_out_commit <= w_out_commit_n;
      r_in_commit  <= w_in_commit_n;
      r_timeout    <= w_timeout_n;
    end
  end

  // Wait timer: cleared on every state entry, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || (w_state_n != r_state)) begin
      r_timer <= '0;
    end else if (r_timer != {C_TW{1'b1}}) begin
      r_timer <= r_timer + C_TW'(1);
    end
  end

  // Next-state and response selection; rx_err beats rx_done beats timeout.
  always_comb begin
    w_state_n      = r_state;
    w_setup_n      = r_setup;
    w_tx_pid_n     = r_tx_pid;
    w_toggle_n     = r_toggle;
    w_tx_start_n   = 1'b0;
    w_out_commit_n = 1'b0;
    w_in_commit_n  = 1'b0;
    w_timeout_n    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rx_err && rx_done) begin
          if (rx_pid == C_PID_IN) begin
            if (app_stall)      w_tx_pid_n = C_PID_STALL;
            else if (app_ready) w_tx_pid_n = r_toggle ? C_PID_DATA1 : C_PID_DATA0;
            else                w_tx_pid_n = C_PID_NAK;
            w_state_n = S_TX_DLY;
          end else if ((rx_pid == C_PID_OUT) || (rx_pid == C_PID_SETUP)) begin
            w_setup_n = (rx_pid == C_PID_SETUP);
            w_state_n = S_WAIT_DATA;
          end
        end
      end
      S_WAIT_DATA: begin
        if (rx_err) begin
          w_state_n = S_IDLE;
        end else if (rx_done) begin
          if (w_rx_is_data) begin
            w_state_n = S_TX_DLY;
            if (r_setup) begin
              // SETUP data is always accepted and forces the data stage to DATA1.
              w_tx_pid_n     = C_PID_ACK;
              w_out_commit_n = 1'b1;
              w_toggle_n     = 1'b1;
            end else if (app_stall) begin
              w_tx_pid_n = C_PID_STALL;
            end else if (!app_out_ack) begin
              w_tx_pid_n = C_PID_NAK;
            end else begin
              // A toggle mismatch is a retry of data already taken: ACK only.
              w_tx_pid_n = C_PID_ACK;
              if (rx_pid[3] == r_toggle) begin
                w_out_commit_n = 1'b1;
                w_toggle_n     = ~r_toggle;
              end
            end
          end else begin
            w_state_n = S_IDLE;
          end
        end else if (w_rx_last) begin
          w_timeout_n = 1'b1;
          w_state_n   = S_IDLE;
        end
      end
      S_TX_DLY: begin
        if (r_timer == C_DLY_LAST) begin
          w_tx_start_n = 1'b1;
          w_state_n    = S_TX;
        end
      end
      S_TX: begin
        if (tx_done) begin
          w_state_n = w_tx_is_data ? S_WAIT_HS : S_IDLE;
        end
      end
      S_WAIT_HS: begin
        if (rx_err) begin
          w_state_n = S_IDLE;
        end else if (rx_done) begin
          if (rx_pid == C_PID_ACK) begin
            w_in_commit_n = 1'b1;
            w_toggle_n    = ~r_toggle;
          end
          w_state_n = S_IDLE;
        end else if (w_rx_last) begin
          w_timeout_n = 1'b1;
          w_state_n   = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign tx_start      = r_tx_start;
  assign tx_pid        = r_tx_pid;
  assign out_commit    = r_out_commit;
  assign in_commit     = r_in_commit;
  assign trsac_timeout = r_timeout;
  assign busy          = (r_state != S_IDLE);
  assign data_toggle   = r_toggle;

endmodule
`default_nettype wire
